// File: rtl/pa_pkg.sv
// rtl/pa_pkg.sv - shared types and pipeline-placement helper for the pa_pipe adder
package pa_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  // Returns the register stage index (1..pipe-1) that sits right after the
  // given prefix-tree logic level, or 0 when no register follows that level.
  function automatic int stage_after(input int level, input int levels, input int pipe);
    int stg;
    stg = 0;
    for (int j = 1; j < pipe; j++) begin
      if (((j * levels) / pipe) - 1 == level) begin
        stg = j;
      end
    end
    return stg;
  endfunction

endpackage

// File: rtl/pa_prefix_level.sv
// rtl/pa_prefix_level.sv - one Kogge-Stone level: combine each P/G pair with the pair SPAN positions below
module pa_prefix_level #(
  parameter int N    = 8,
  parameter int SPAN = 1
) (
  input  logic [N-1:0] p_in,
  input  logic [N-1:0] g_in,
  output logic [N-1:0] p_out,
  output logic [N-1:0] g_out
);

  // Positions below SPAN already hold their complete prefix and pass through.
  always_comb begin
    p_out = p_in;
    g_out = g_in;
    for (int i = SPAN; i < N; i++) begin
      g_out[i] = g_in[i] | (p_in[i] & g_in[i-SPAN]);
      p_out[i] = p_in[i] & p_in[i-SPAN];
    end
  end

endmodule

// File: rtl/pa_pipe.sv
// rtl/pa_pipe.sv - pipelined Kogge-Stone add/sub with valid/ready handshake and bubble collapse
module pa_pipe
  import pa_pkg::*;
#(
  parameter int N    = 8,
  parameter int PIPE = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  input  op_t          op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] y,
  output logic         c_out,
  output logic         ovf,
  output logic         zero
);

  localparam int L = $clog2(N) + 1;

  // Prefix vectors are indexed by position: position 0 carries the carry-in
  // (g = cin, p = 0) and position i>0 carries operand bit i-1, so after the
  // last level gg[i] is exactly the carry into sum bit i.
  logic [N-1:0] lo_pb [L];
  logic [N-1:0] lo_pp [L];
  logic [N-1:0] lo_gg [L];
  logic         lo_gm [L];
  logic [N-1:0] po_pb [L];
  logic [N-1:0] po_pp [L];
  logic [N-1:0] po_gg [L];
  logic         po_gm [L];

  logic [PIPE:1]   vld;
  logic [PIPE+1:0] full;
  logic [PIPE+1:0] go;

  logic [N-1:0] bb;
  logic         cin_eff;
  logic [N-1:0] pbit;
  logic [N-1:0] gbit;

  logic [N-1:0] y_d;
  logic         c_d;
  logic         ovf_d;
  logic         zero_d;
  logic         unused_pp;

  // Position 0 stands for the input side; position PIPE+1 is the sink, treated
  // as always occupied and draining whenever out_ready is high.
  assign full = {1'b1, vld, in_valid};

  // go[k]: stage k hands its data on this cycle (go[0] = transaction accepted).
  always_comb begin
    logic [PIPE+1:0] g;
    g = '0;
    g[PIPE+1] = out_ready;
    for (int k = PIPE; k >= 0; k--) begin
      g[k] = full[k] & (~full[k+1] | g[k+1]);
    end
    go = g;
  end

  assign in_ready  = ~vld[1] | go[1];
  assign out_valid = vld[PIPE];

  // Per-stage occupancy: fill from upstream, empty when handing on without a refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else begin
      for (int k = 1; k <= PIPE; k++) begin
        vld[k] <= go[k-1] | (vld[k] & ~go[k]);
      end
    end
  end

  // Subtraction is a + ~b + 1; c_in only matters for addition.
  assign bb      = (op == OP_SUB) ? ~b : b;
  assign cin_eff = (op == OP_SUB) ? 1'b1 : c_in;
  assign pbit    = a ^ bb;
  assign gbit    = a & bb;

  for (genvar l = 0; l < L; l++) begin : g_lvl
    localparam int STG = stage_after(l, L, PIPE);

    if (l == 0) begin : g_pg
      assign lo_pb[0] = pbit;
      assign lo_pp[0] = {pbit[N-2:0], 1'b0};
      assign lo_gg[0] = {gbit[N-2:0], cin_eff};
      assign lo_gm[0] = gbit[N-1];
    end else begin : g_pre
      pa_prefix_level #(
        .N    (N),
        .SPAN (1 << (l - 1))
      ) u_level (
        .p_in  (po_pp[l-1]),
        .g_in  (po_gg[l-1]),
        .p_out (lo_pp[l]),
        .g_out (lo_gg[l])
      );
      assign lo_pb[l] = po_pb[l-1];
      assign lo_gm[l] = po_gm[l-1];
    end

    if (STG != 0) begin : g_reg
      logic [N-1:0] pb_q;
      logic [N-1:0] pp_q;
      logic [N-1:0] gg_q;
      logic         gm_q;

      // Internal stage register: data only, occupancy lives in vld.
      always_ff @(posedge clk) begin
        if (go[STG-1]) begin
          pb_q <= lo_pb[l];
          pp_q <= lo_pp[l];
          gg_q <= lo_gg[l];
          gm_q <= lo_gm[l];
        end
      end

      assign po_pb[l] = pb_q;
      assign po_pp[l] = pp_q;
      assign po_gg[l] = gg_q;
      assign po_gm[l] = gm_q;
    end else begin : g_wire
      assign po_pb[l] = lo_pb[l];
      assign po_pp[l] = lo_pp[l];
      assign po_gg[l] = lo_gg[l];
      assign po_gm[l] = lo_gm[l];
    end
  end

  // Sum, carry-out and flags. When both MSBs agree pbit is 0 and gbit equals
  // that shared MSB, which gives overflow without keeping the raw operands.
  assign y_d       = po_pb[L-1] ^ po_gg[L-1];
  assign c_d       = po_gm[L-1] | (po_pb[L-1][N-1] & po_gg[L-1][N-1]);
  assign ovf_d     = ~po_pb[L-1][N-1] & (y_d[N-1] ^ po_gm[L-1]);
  assign zero_d    = (y_d == '0);
  assign unused_pp = ^po_pp[L-1];

  // Output register: loads only when the last stage takes new data, so it holds under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y     <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else if (go[PIPE-1]) begin
      y     <= y_d;
      c_out <= c_d;
      ovf   <= ovf_d;
      zero  <= zero_d;
    end
  end

endmodule

// File: doc/pa_pipe.md
PA_PIPE -- requirements
Module: pa_pipe

Interface
REQ-001 SHALL have parameter N, default 8: operand width in bits, legal range 2..64.
REQ-002 SHALL have parameter PIPE, default 2: number of register stages, i.e. the latency in cycles, legal range 1..$clog2(N)+1.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have ports in_valid (input, 1) and in_ready (output, 1): upstream handshake.
REQ-006 SHALL have ports a and b, input, N each: operands.
REQ-007 SHALL have port c_in, input, 1: carry-in, used in ADD mode only.
REQ-008 SHALL have port op, input, op_t: OP_ADD or OP_SUB.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1): downstream handshake.
REQ-010 SHALL have port y, output, N: result.
REQ-011 SHALL have ports c_out, ovf and zero, output, 1 each: carry out, signed overflow, result-is-zero.

Function
REQ-012 SHALL compute y/c_out as {c_out,y} = a + b + c_in for OP_ADD, and a + ~b + 1 for OP_SUB (c_in ignored; c_out=1 means no borrow).
REQ-013 SHALL assert ovf when both adder inputs have equal MSBs and y's MSB differs; zero = (y == 0).
REQ-014 SHALL implement the carry network as a Kogge-Stone prefix tree: L = $clog2(N)+1 logic levels (level 0 = bitwise P/G, levels 1..L-1 = prefix span 2^(level-1)), with carry-in folded in at position -1.
REQ-015 SHALL place internal register boundary j (j = 1..PIPE-1) after logic level floor(j*L/PIPE)-1, plus one always-present output register; the sum XOR and flags are computed before the output register.
REQ-016 SHALL accept a transaction on any cycle where in_valid && in_ready, and present its result exactly PIPE cycles later when there is no backpressure.
REQ-017 SHALL keep a per-stage valid bit; stage k loads when its upstream valid is set and (stage k is empty, or stage k advances this cycle).
REQ-018 SHALL advance the last stage when out_valid && out_ready; in_ready = stage 1 empty or stage 1 advancing (combinational path from out_ready is permitted).
REQ-019 SHALL collapse bubbles: an empty stage accepts data even while downstream stages are stalled.
REQ-020 SHALL hold y, c_out, ovf, zero and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL sustain one result per cycle with out_ready held high, and never drop, duplicate or reorder transactions.
REQ-022 SHALL treat in_valid with in_ready low as not accepted; operands may change freely in that state.

Reset
REQ-023 SHALL on rst_n low asynchronously clear all stage valid bits, out_valid, y, c_out, ovf and zero to 0.
REQ-024 SHALL discard in-flight transactions on reset mid-operation; in_ready SHALL be 1 on the first cycle after reset release.
REQ-025 Internal data registers other than outputs MAY be left unreset.

Structure
REQ-026 SHALL place op_t (enum OP_ADD=0, OP_SUB=1) in shared package pa_pkg.
REQ-027 SHALL use one sub-module pa_prefix_level (params N, SPAN; combinational P/G combine of one level), instantiated L-1 times.

Verification
REQ-028 N=8, PIPE=3, ADD a=8'hFF b=8'h01 c_in=0 -> 3 cycles later y=8'h00, c_out=1, zero=1, ovf=0.
REQ-029 SUB a=8'h80 b=8'h01 -> y=8'h7F, c_out=1, ovf=1; SUB a=8'h00 b=8'h01 -> y=8'hFF, c_out=0.
REQ-030 Back-to-back 100 random transactions, out_ready=1 -> one result per cycle, all match reference model, in order.
REQ-031 out_ready=0 for 10 cycles with in_valid=1 -> exactly PIPE transactions accepted, in_ready=0 afterwards, outputs stable; release -> all delivered in order.
REQ-032 Single transaction, then rst_n pulsed low at cycle 1 -> out_valid never asserts; the next transaction completes normally.
REQ-033 Sweep N in {2,5,16,32}, PIPE in {1..L} -> exhaustive (N<=5) or random check passes and latency = PIPE.
